// File: rtl/unit_output_collector_pkg.sv
// Shared definitions for the bcrypt unit output collector: default sizes and
// the collector FSM state encoding.
package unit_output_collector_pkg;

  // Result word MSB; the word is DEF_MSB+1 bits wide.
  localparam int DEF_MSB         = 31;
  // Width of the packet word counter (max packet = 2^DEF_WORDS_NBITS-1 words).
  localparam int DEF_WORDS_NBITS = 4;
  // Output buffer depth in words (power of two, at least 2).
  localparam int DEF_BUF_DEPTH   = 2;

  // Collector FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    STORE     = 2'd3
  } state_t;

endpackage

// File: rtl/unit_output_buf.sv
// Small synchronous FIFO holding completed result words ({last, data}).
// The head entry is kept in an output register so rd_data/rd_valid are
// flop outputs; a word pushed into an empty buffer is visible next cycle.
module unit_output_buf #(
  parameter int DATA_W = 33,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  remain;
  logic              do_push;
  logic              do_pop;
  logic [DATA_W-1:0] head_next;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == CNT_W'(0));

  // Pop/push qualification and the next head word; a push into a buffer that
  // becomes empty after this cycle's pop bypasses straight to the head.
  always_comb begin
    do_pop      = !empty && rd_ready;
    do_push     = push && (!full || do_pop);
    rd_ptr_next = do_pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    remain      = count - CNT_W'(do_pop);
    count_next  = remain + CNT_W'(do_push);
    if (remain == CNT_W'(0)) begin
      head_next = push_data;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  // Storage array write; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head/valid outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= PTR_W'(0);
      rd_ptr   <= PTR_W'(0);
      count    <= CNT_W'(0);
      rd_valid <= 1'b0;
      rd_data  <= DATA_W'(0);
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      rd_valid <= (count_next != CNT_W'(0));
      if (count_next != CNT_W'(0)) begin
        rd_data <= head_next;
      end
    end
  end

endmodule

// File: rtl/unit_output_collector.sv
// Collects a bcrypt unit's serial result: walks output_cnt over the unit's
// Ltmp word, assembles it LSB-first, and hands finished words (tagged with
// last) to a small FIFO feeding the 32-bit valid/ready output stream.
module unit_output_collector
  import unit_output_collector_pkg::*;
#(
  parameter int MSB         = DEF_MSB,
  parameter int WORDS_NBITS = DEF_WORDS_NBITS,
  parameter int BUF_DEPTH   = DEF_BUF_DEPTH
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       pkt_start,
  input  logic [WORDS_NBITS-1:0]     pkt_nwords,
  output logic                       busy,
  input  logic                       unit_word_valid,
  output logic                       unit_word_done,
  output logic [$clog2(MSB+1)-1:0]   output_cnt,
  input  logic                       unit_out,
  output logic [MSB:0]               dout,
  output logic                       dout_last,
  output logic                       dout_valid,
  input  logic                       dout_ready
);

  localparam int CNT_W = $clog2(MSB + 1);

  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt_next;
  logic [MSB:0]           shreg;
  logic [WORDS_NBITS-1:0] words_left;
  logic [WORDS_NBITS-1:0] words_left_next;
  logic                   push;
  logic                   push_ok;
  logic                   buf_full;
  logic                   buf_empty;
  logic [MSB+1:0]         buf_data;

  // A push is legal when there is room, or the head leaves this same cycle.
  assign push_ok = !buf_full || (!buf_empty && dout_ready);

  // Next-state, bit-select and word-counter logic.
  always_comb begin
    state_next      = state;
    cnt_next        = CNT_W'(0);
    words_left_next = words_left;
    push            = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_start && (pkt_nwords != WORDS_NBITS'(0))) begin
          words_left_next = pkt_nwords;
          state_next      = WAIT_WORD;
        end else begin
          state_next      = IDLE;
        end
      end
      WAIT_WORD: begin
        if (unit_word_valid) begin
          state_next = SHIFT;
        end else begin
          state_next = WAIT_WORD;
        end
      end
      SHIFT: begin
        if (output_cnt == CNT_W'(MSB)) begin
          state_next = STORE;
          cnt_next   = CNT_W'(0);
        end else begin
          state_next = SHIFT;
          cnt_next   = output_cnt + CNT_W'(1);
        end
      end
      STORE: begin
        if (push_ok && !reset) begin
          push            = 1'b1;
          words_left_next = words_left - WORDS_NBITS'(1);
          if (words_left == WORDS_NBITS'(1)) begin
            state_next = IDLE;
          end else begin
            state_next = WAIT_WORD;
          end
        end else begin
          state_next = STORE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The controller may reload Ltmp as soon as the word is in the buffer.
  assign unit_word_done = push;

  // FSM state, bit select, word counter and busy flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      output_cnt <= CNT_W'(0);
      words_left <= WORDS_NBITS'(0);
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      output_cnt <= cnt_next;
      words_left <= words_left_next;
      busy       <= (state_next != IDLE);
    end
  end

  // Deserializer: the unit's bit for index output_cnt lands in that position.
  always_ff @(posedge CLK) begin
    if (reset) begin
      shreg <= '{default: 1'b0};
    end else if (state == SHIFT) begin
      shreg[output_cnt] <= unit_out;
    end
  end

  unit_output_buf #(
    .DATA_W (MSB + 2),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (CLK),
    .reset     (reset),
    .push      (push),
    .push_data ({(words_left == WORDS_NBITS'(1)), shreg}),
    .full      (buf_full),
    .empty     (buf_empty),
    .rd_data   (buf_data),
    .rd_valid  (dout_valid),
    .rd_ready  (dout_ready)
  );

  assign dout      = buf_data[MSB:0];
  assign dout_last = buf_data[MSB+1];

endmodule
